// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, FIFO sizing defaults and TX feeder FSM states.
// Pure definitions, no latency or backpressure of its own.
// Reused by the RX-side FIFO path.
package uart_pkg;

    localparam int UART_W          = 8;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_TIMEOUT_CYC = 200000;

    typedef logic [UART_W-1:0] uart_byte_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host push side plus UART_TX start/busy/done handshake of the TX byte feeder.
// Wires only; the slave modport is the feeder, the master modport is host plus UART_TX.
// Backpressure is reported through full/level; pushes at full are dropped, not stalled.
interface uart_tx_fifo_if #(
    parameter int DEPTH = uart_pkg::DEF_DEPTH
);

    localparam int AW = $clog2(DEPTH);

    logic                clr;
    logic                wr_en;
    uart_pkg::uart_byte_t wr_data;
    logic                full;
    logic                empty;
    logic [AW:0]         level;
    logic                overflow;
    logic                timeout;
    logic                tx_en;
    uart_pkg::uart_byte_t tx_data;
    logic                tx_busy;
    logic                tx_done;

    modport master (
        output clr, wr_en, wr_data, tx_busy, tx_done,
        input  full, empty, level, overflow, timeout, tx_en, tx_data
    );

    modport slave (
        input  clr, wr_en, wr_data, tx_busy, tx_done,
        output full, empty, level, overflow, timeout, tx_en, tx_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with synchronous flush; full/empty decode the registered count.
// Write takes effect at the push edge; pop_dat is the head entry, valid combinationally.
// No stall: a push at full and a pop at empty are ignored by the storage.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // full/empty are looked at before this cycle's pop, so a push at full is lost even when a pop frees a slot
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered byte feeder for UART_TX with sticky overflow and hung-transmitter flags.
// Latency: byte pushed at edge E0 into an empty FIFO gives a one-cycle tx_en after E1.
// Backpressure: waits for !tx_busy before each frame; pushes at full are dropped and flagged.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          arst,
    uart_tx_fifo_if.slave bus
);

    localparam int  AW     = $clog2(DEPTH);
    localparam int  CW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit  TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic          start;
    logic          tmo_hit;
    logic [CW-1:0] tmo_cnt;

    uart_byte_t    fifo_dat;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    sync_fifo #(
        .W     (UART_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .clr      (bus.clr),
        .push     (bus.wr_en),
        .push_dat (bus.wr_data),
        .pop      (start),
        .pop_dat  (fifo_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;
    assign bus.level = fifo_count;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (bus.tx_done || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A flush in the same cycle wins over launching the head byte, so flushed data is never sent
    always_comb begin
        start   = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            IDLE:    start   = !fifo_empty && !bus.tx_busy && !bus.clr;
            SEND:    tmo_hit = TMO_EN && !bus.tx_done && (tmo_cnt == TMO_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bus.tx_en    <= 1'b0;
            bus.tx_data  <= '0;
            bus.overflow <= 1'b0;
            bus.timeout  <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            bus.tx_en <= start;
            if (start) bus.tx_data <= fifo_dat;

            // counts SEND cycles since tx_en; a frame in flight keeps counting through clr
            if (state == SEND && state_nxt == SEND) tmo_cnt <= tmo_cnt + 1'b1;
            else                                    tmo_cnt <= '0;

            if (bus.clr) begin
                bus.overflow <= 1'b0;
                bus.timeout  <= 1'b0;
            end else begin
                if (bus.wr_en && fifo_full) bus.overflow <= 1'b1;
                if (tmo_hit)                bus.timeout  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural UART_TX responder plus byte-stream scoreboard.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus_if ();

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_if.slave)
    );

    int   checks = 0;
    int   passed = 0;
    bit   resp_en = 1'b0;
    logic r_busy = 1'b0, r_done = 1'b0;
    logic man_busy = 1'b0, man_done = 1'b0;
    int   len_lo = 2, len_hi = 6;
    int   busy_cnt = 0;
    int   pulses = 0, proto_err = 0;
    bit   prev_en = 1'b0;
    logic [7:0] got [$];

    assign bus_if.tx_busy = resp_en ? r_busy : man_busy;
    assign bus_if.tx_done = resp_en ? r_done : man_done;

    // UART_TX stand-in: busy for a random frame length after each tx_en, then a one-cycle done
    initial begin
        forever begin
            @(posedge clk); #1;
            if (arst) begin
                busy_cnt = 0; prev_en = 1'b0; r_busy = 1'b0; r_done = 1'b0;
            end else begin
                if (bus_if.tx_en) begin
                    pulses++;
                    if (prev_en || busy_cnt > 0) proto_err++;
                end
                prev_en = bus_if.tx_en;
                r_done  = 1'b0;
                if (!resp_en) begin
                    busy_cnt = 0; r_busy = 1'b0;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin r_busy = 1'b0; r_done = 1'b1; end
                end else if (bus_if.tx_en) begin
                    got.push_back(bus_if.tx_data);
                    r_busy   = 1'b1;
                    busy_cnt = $urandom_range(len_hi, len_lo);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = b;
        tick();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic wait_drained(input int n, input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (got.size() >= n && !bus_if.tx_busy && bus_if.empty && !bus_if.tx_en) break;
            tick();
        end
        repeat (2) tick();
        checks++;
        if (k >= 3000) $display("FAIL %s: drain not reached, got %0d bytes want %0d", tag, got.size(), n);
        else passed++;
    endtask

    task automatic test_reset();
        checks++; if (bus_if.level !== 5'd0)    $display("FAIL reset_level: got %0d want 0", bus_if.level); else passed++;
        checks++; if (bus_if.empty !== 1'b1)    $display("FAIL reset_empty: got %b want 1", bus_if.empty); else passed++;
        checks++; if (bus_if.full !== 1'b0)     $display("FAIL reset_full: got %b want 0", bus_if.full); else passed++;
        checks++; if (bus_if.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus_if.overflow); else passed++;
        checks++; if (bus_if.timeout !== 1'b0)  $display("FAIL reset_timeout: got %b want 0", bus_if.timeout); else passed++;
        checks++; if (bus_if.tx_en !== 1'b0)    $display("FAIL reset_tx_en: got %b want 0", bus_if.tx_en); else passed++;
        checks++; if (bus_if.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus_if.tx_data); else passed++;
        tick();
    endtask

    task automatic test_single();
        int base, p0;
        logic [7:0] a;
        resp_en = 1'b1; len_lo = 4; len_hi = 8;
        base = got.size(); p0 = pulses;
        push_byte(8'hA5);
        checks++; if (bus_if.level !== 5'd1) $display("FAIL single_level_push: got %0d want 1", bus_if.level); else passed++;
        checks++; if (bus_if.tx_en !== 1'b0) $display("FAIL single_en_early: got %b want 0", bus_if.tx_en); else passed++;
        tick();
        checks++; if (bus_if.tx_en !== 1'b1)    $display("FAIL single_en: got %b want 1", bus_if.tx_en); else passed++;
        checks++; if (bus_if.tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", bus_if.tx_data); else passed++;
        checks++; if (bus_if.level !== 5'd0)    $display("FAIL single_level_pop: got %0d want 0", bus_if.level); else passed++;
        tick();
        checks++; if (bus_if.tx_en !== 1'b0) $display("FAIL single_en_width: got %b want 0", bus_if.tx_en); else passed++;
        wait_drained(base + 1, "single_drain");
        a = (base < got.size()) ? got[base] : 8'hxx;
        checks++; if (a !== 8'hA5) $display("FAIL single_rx: got %h want a5", a); else passed++;
        checks++; if (bus_if.empty !== 1'b1) $display("FAIL single_empty: got %b want 1", bus_if.empty); else passed++;
        checks++; if (pulses - p0 !== 1) $display("FAIL single_pulses: got %0d want 1", pulses - p0); else passed++;
    endtask

    task automatic test_burst();
        int base, p0;
        logic [7:0] a;
        man_busy = 1'b1; resp_en = 1'b0;
        base = got.size(); p0 = pulses;
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        checks++; if (bus_if.level !== 5'd4) $display("FAIL burst_level: got %0d want 4", bus_if.level); else passed++;
        checks++; if (pulses !== p0) $display("FAIL burst_start_while_busy: got %0d want %0d", pulses, p0); else passed++;
        len_lo = 3; len_hi = 8; resp_en = 1'b1; man_busy = 1'b0;
        wait_drained(base + 4, "burst_drain");
        checks++; if (pulses - p0 !== 4) $display("FAIL burst_pulses: got %0d want 4", pulses - p0); else passed++;
        for (int i = 0; i < 4; i++) begin
            a = (base + i < got.size()) ? got[base + i] : 8'hxx;
            checks++; if (a !== 8'(i + 1)) $display("FAIL burst_order[%0d]: got %h want %h", i, a, 8'(i + 1)); else passed++;
        end
        checks++; if (proto_err !== 0) $display("FAIL burst_protocol: got %0d errors want 0", proto_err); else passed++;
    endtask

    task automatic test_overflow();
        int p0;
        man_busy = 1'b1; man_done = 1'b0; resp_en = 1'b0;
        p0 = pulses;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i));
        checks++; if (bus_if.full !== 1'b1)     $display("FAIL ovf_full16: got %b want 1", bus_if.full); else passed++;
        checks++; if (bus_if.overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus_if.overflow); else passed++;
        push_byte(8'hFF);
        checks++; if (bus_if.overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus_if.overflow); else passed++;
        checks++; if (bus_if.level !== 5'd16)   $display("FAIL ovf_level: got %0d want 16", bus_if.level); else passed++;
        checks++; if (pulses !== p0)            $display("FAIL ovf_no_start: got %0d want %0d", pulses, p0); else passed++;
        bus_if.clr = 1'b1; tick(); bus_if.clr = 1'b0;
        checks++; if (bus_if.level !== 5'd0)    $display("FAIL ovf_clr_level: got %0d want 0", bus_if.level); else passed++;
        checks++; if (bus_if.overflow !== 1'b0) $display("FAIL ovf_clr_flag: got %b want 0", bus_if.overflow); else passed++;
        checks++; if (bus_if.empty !== 1'b1)    $display("FAIL ovf_clr_empty: got %b want 1", bus_if.empty); else passed++;
    endtask

    task automatic test_push_full_pop();
        man_busy = 1'b1; resp_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + i));
        checks++; if (bus_if.overflow !== 1'b0) $display("FAIL pfp_pre_ovf: got %b want 0", bus_if.overflow); else passed++;
        man_busy = 1'b0;
        bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hEE;
        tick();
        bus_if.wr_en = 1'b0;
        checks++; if (bus_if.level !== 5'd15)   $display("FAIL pfp_level: got %0d want 15", bus_if.level); else passed++;
        checks++; if (bus_if.overflow !== 1'b1) $display("FAIL pfp_ovf: got %b want 1", bus_if.overflow); else passed++;
        checks++; if (bus_if.tx_en !== 1'b1)    $display("FAIL pfp_en: got %b want 1", bus_if.tx_en); else passed++;
        checks++; if (bus_if.tx_data !== 8'h40) $display("FAIL pfp_data: got %h want 40", bus_if.tx_data); else passed++;
        man_busy = 1'b1;
        bus_if.clr = 1'b1; tick(); bus_if.clr = 1'b0;
        checks++; if (bus_if.level !== 5'd0)    $display("FAIL pfp_clr_level: got %0d want 0", bus_if.level); else passed++;
        checks++; if (bus_if.tx_data !== 8'h40) $display("FAIL pfp_clr_hold: got %h want 40", bus_if.tx_data); else passed++;
        man_done = 1'b1; tick(); man_done = 1'b0; man_busy = 1'b0;
        repeat (2) tick();
        checks++; if (bus_if.tx_en !== 1'b0) $display("FAIL pfp_after_en: got %b want 0", bus_if.tx_en); else passed++;
        checks++; if (bus_if.empty !== 1'b1) $display("FAIL pfp_after_empty: got %b want 1", bus_if.empty); else passed++;
    endtask

    task automatic test_timeout();
        int n, p0;
        man_busy = 1'b0; man_done = 1'b0; resp_en = 1'b0;
        p0 = pulses;
        push_byte(8'h3C);
        tick();
        checks++; if (bus_if.tx_en !== 1'b1)    $display("FAIL tmo_en: got %b want 1", bus_if.tx_en); else passed++;
        checks++; if (bus_if.tx_data !== 8'h3C) $display("FAIL tmo_data: got %h want 3c", bus_if.tx_data); else passed++;
        man_busy = 1'b1;
        push_byte(8'hC3);
        n = 1;
        while (!bus_if.timeout && n < 300) begin tick(); n++; end
        checks++; if (n !== TMO) $display("FAIL tmo_delay: got %0d cycles want %0d", n, TMO); else passed++;
        checks++; if (bus_if.level !== 5'd1) $display("FAIL tmo_level: got %0d want 1", bus_if.level); else passed++;
        repeat (10) tick();
        checks++; if (pulses !== p0 + 1)       $display("FAIL tmo_wait_busy: got %0d pulses want %0d", pulses - p0, 1); else passed++;
        checks++; if (bus_if.timeout !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", bus_if.timeout); else passed++;
        man_busy = 1'b0;
        tick();
        checks++; if (bus_if.tx_en !== 1'b1)    $display("FAIL tmo_next_en: got %b want 1", bus_if.tx_en); else passed++;
        checks++; if (bus_if.tx_data !== 8'hC3) $display("FAIL tmo_next_data: got %h want c3", bus_if.tx_data); else passed++;
        man_busy = 1'b1;
        bus_if.clr = 1'b1; tick(); bus_if.clr = 1'b0;
        checks++; if (bus_if.timeout !== 1'b0) $display("FAIL tmo_clr: got %b want 0", bus_if.timeout); else passed++;
        man_done = 1'b1; tick(); man_done = 1'b0; man_busy = 1'b0;
        repeat (2) tick();
        p0 = pulses;
        man_done = 1'b1; tick(); man_done = 1'b0;
        repeat (3) tick();
        checks++; if (pulses !== p0)           $display("FAIL idle_done_ignored: got %0d pulses want 0", pulses - p0); else passed++;
        checks++; if (bus_if.timeout !== 1'b0) $display("FAIL tmo_after_done: got %b want 0", bus_if.timeout); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] sent [$];
        logic [7:0] a;
        int base, p0;
        logic [7:0] b;
        resp_en = 1'b1; len_lo = 1; len_hi = 15;
        base = got.size(); p0 = pulses;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2, 0) == 0 && (sent.size() - (pulses - p0)) < DEPTH - 2) begin
                b = 8'($urandom_range(255, 0));
                bus_if.wr_en = 1'b1; bus_if.wr_data = b;
                sent.push_back(b);
            end else begin
                bus_if.wr_en = 1'b0;
            end
            tick();
        end
        bus_if.wr_en = 1'b0;
        wait_drained(base + sent.size(), "random_drain");
        checks++; if (got.size() - base !== sent.size()) $display("FAIL rand_count: got %0d want %0d", got.size() - base, sent.size()); else passed++;
        foreach (sent[i]) begin
            a = (base + i < got.size()) ? got[base + i] : 8'hxx;
            checks++; if (a !== sent[i]) $display("FAIL rand_byte[%0d]: got %h want %h", i, a, sent[i]); else passed++;
        end
        checks++; if (bus_if.overflow !== 1'b0) $display("FAIL rand_ovf: got %b want 0", bus_if.overflow); else passed++;
        checks++; if (proto_err !== 0) $display("FAIL rand_protocol: got %0d errors want 0", proto_err); else passed++;
    endtask

    task automatic test_reset_midframe();
        int p1;
        resp_en = 1'b1; len_lo = 400; len_hi = 400;
        for (int i = 0; i < 4; i++) push_byte(8'(8'h70 + i));
        repeat (47) tick();
        checks++; if (bus_if.level !== 5'd3) $display("FAIL rmf_level_pre: got %0d want 3", bus_if.level); else passed++;
        #2 arst = 1'b1;
        #1;
        checks++; if (bus_if.tx_en !== 1'b0)    $display("FAIL rmf_tx_en: got %b want 0", bus_if.tx_en); else passed++;
        checks++; if (bus_if.level !== 5'd0)    $display("FAIL rmf_level: got %0d want 0", bus_if.level); else passed++;
        checks++; if (bus_if.empty !== 1'b1)    $display("FAIL rmf_empty: got %b want 1", bus_if.empty); else passed++;
        checks++; if (bus_if.tx_data !== 8'h00) $display("FAIL rmf_tx_data: got %h want 00", bus_if.tx_data); else passed++;
        checks++; if (bus_if.overflow !== 1'b0 || bus_if.timeout !== 1'b0)
            $display("FAIL rmf_flags: got ovf=%b tmo=%b want 0 0", bus_if.overflow, bus_if.timeout); else passed++;
        repeat (2) @(posedge clk);
        #3 arst = 1'b0;
        p1 = pulses;
        repeat (30) tick();
        checks++; if (pulses !== p1)         $display("FAIL rmf_no_restart: got %0d pulses want 0", pulses - p1); else passed++;
        checks++; if (bus_if.level !== 5'd0) $display("FAIL rmf_level_post: got %0d want 0", bus_if.level); else passed++;
    endtask

    initial begin
        arst           = 1'b1;
        bus_if.clr     = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #3 arst = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_full_pop();
        test_timeout();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
